// File: rtl/gray_stream_decoder.sv
// Gray-to-binary stream decoder: one output register behind valid/ready, with
// step direction, illegal-transition flag and a saturating error counter.
module gray_stream_decoder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             dir_up,
  output logic             step_err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {FIRST, TRACK} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] ref_gray;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] new_bin;
  logic             accept;
  logic             nxt_err;
  logic             nxt_dir;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign diff     = gray_in ^ ref_gray;

  // Prefix-XOR from the MSB down, built from shifted copies of the whole word.
  always_comb begin
    new_bin = gray_in;
    for (int unsigned i = 1; i < WIDTH; i++)
      new_bin = new_bin ^ (gray_in >> i);
  end

  // bin_out is loaded on every accept, exactly like ref_gray, so it doubles as
  // the reference word's binary value.
  always_comb begin
    state_nx = state;
    nxt_err  = 1'b0;
    nxt_dir  = dir_up;
    if (accept) begin
      case (state)
        FIRST: state_nx = TRACK;
        TRACK: begin
          if ((diff & (diff - WIDTH'(1))) != '0)
            nxt_err = 1'b1;
          else if (diff != '0)
            nxt_dir = (new_bin == bin_out + WIDTH'(1));
        end
        default: state_nx = FIRST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FIRST;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_gray  <= '0;
      out_valid <= 1'b0;
      bin_out   <= '0;
      dir_up    <= 1'b1;
      step_err  <= 1'b0;
      err_cnt   <= '0;
    end else if (accept) begin
      ref_gray  <= gray_in;
      out_valid <= 1'b1;
      bin_out   <= new_bin;
      dir_up    <= nxt_dir;
      step_err  <= nxt_err;
      if (nxt_err && err_cnt != '1)
        err_cnt <= err_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Bench for gray_stream_decoder: directed scenarios with literal expectations
// plus a randomized run checked cycle-by-cycle against a behavioural model.
module tb_gray_stream_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] gray_in = 4'd0;

  logic       in_ready8, out_valid8, dir_up8, step_err8;
  logic [3:0] bin_out8;
  logic [7:0] err_cnt8;
  logic       in_ready2, out_valid2, dir_up2, step_err2;
  logic [3:0] bin_out2;
  logic [1:0] err_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gray_stream_decoder #(.WIDTH(4), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .gray_in(gray_in), .out_valid(out_valid8), .out_ready(out_ready),
    .bin_out(bin_out8), .dir_up(dir_up8), .step_err(step_err8), .err_cnt(err_cnt8)
  );

  gray_stream_decoder #(.WIDTH(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .gray_in(gray_in), .out_valid(out_valid2), .out_ready(out_ready),
    .bin_out(bin_out2), .dir_up(dir_up2), .step_err(step_err2), .err_cnt(err_cnt2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Gray to binary as the XOR of all right shifts of the code word.
  function automatic int g2b(input int g);
    int b = 0;
    for (int k = 0; k < 4; k++) b = b ^ (g >> k);
    return b & 15;
  endfunction

  // Model state describes the outputs after the most recent rising edge.
  int m_known = 0, m_valid = 0, m_bin = 0, m_dir = 1, m_err = 0;
  int m_cnt8 = 0, m_cnt2 = 0, m_have_ref = 0, m_ref_gray = 0, m_ref_bin = 0;

  // Inputs change just after a rising edge, so at the falling edge they are
  // exactly what the next rising edge will sample: compare first, then advance.
  initial begin
    int b, pc;
    forever begin
      @(negedge clk);
      if (m_known != 0) begin
        check("in_ready8", int'(in_ready8), int'(m_valid == 0 || out_ready));
        check("in_ready2", int'(in_ready2), int'(m_valid == 0 || out_ready));
        check("out_valid8", int'(out_valid8), m_valid);
        check("out_valid2", int'(out_valid2), m_valid);
        if (m_valid != 0) begin
          check("bin_out8", int'(bin_out8), m_bin);
          check("bin_out2", int'(bin_out2), m_bin);
          check("dir_up8", int'(dir_up8), m_dir);
          check("dir_up2", int'(dir_up2), m_dir);
          check("step_err8", int'(step_err8), m_err);
          check("step_err2", int'(step_err2), m_err);
        end
        check("err_cnt8", int'(err_cnt8), m_cnt8);
        check("err_cnt2", int'(err_cnt2), m_cnt2);
      end
      if (rst) begin
        m_known = 1; m_valid = 0; m_bin = 0; m_dir = 1; m_err = 0;
        m_cnt8 = 0; m_cnt2 = 0; m_have_ref = 0;
      end else if (m_known != 0) begin
        if (in_valid && (m_valid == 0 || out_ready)) begin
          b = g2b(int'(gray_in));
          m_err = 0;
          if (m_have_ref != 0) begin
            pc = $countones(gray_in ^ 4'(m_ref_gray));
            if (pc >= 2) begin
              m_err = 1;
              if (m_cnt8 < 255) m_cnt8++;
              if (m_cnt2 < 3) m_cnt2++;
            end else if (pc == 1) begin
              m_dir = (((b - m_ref_bin) & 15) == 1) ? 1 : 0;
            end
          end
          m_have_ref = 1; m_ref_gray = int'(gray_in); m_ref_bin = b;
          m_bin = b; m_valid = 1;
        end else if (out_ready) begin
          m_valid = 0;
        end
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic [3:0] g, input logic rdy);
    rst = r; in_valid = v; gray_in = g; out_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic expect_word(input string name, input int b, input int d, input int e);
    check({name, ".valid"}, int'(out_valid8), 1);
    check({name, ".bin"}, int'(bin_out8), b);
    check({name, ".dir"}, int'(dir_up8), d);
    check({name, ".err"}, int'(step_err8), e);
  endtask

  initial begin
    logic [3:0] seq [5];
    logic [3:0] cur;
    int r;
    seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};

    // Reset state and monotonic stream
    do_reset();
    check("rst.valid", int'(out_valid8), 0);
    check("rst.bin", int'(bin_out8), 0);
    check("rst.dir", int'(dir_up8), 1);
    check("rst.err", int'(step_err8), 0);
    check("rst.cnt", int'(err_cnt8), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, seq[i], 1'b1);
      expect_word("mono", i, 1, 0);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    check("mono.drain", int'(out_valid8), 0);

    // Wrap in both directions
    do_reset();
    drive(1'b0, 1'b1, 4'b1000, 1'b1);
    expect_word("wrap.first", 15, 1, 0);
    drive(1'b0, 1'b1, 4'b0000, 1'b1);
    expect_word("wrap.up", 0, 1, 0);
    drive(1'b0, 1'b1, 4'b1000, 1'b1);
    expect_word("wrap.down", 15, 0, 0);

    // Illegal jump keeps a down direction, then a legal up step
    do_reset();
    drive(1'b0, 1'b1, 4'b0001, 1'b1);
    drive(1'b0, 1'b1, 4'b0000, 1'b1);
    expect_word("ill.down", 0, 0, 0);
    drive(1'b0, 1'b1, 4'b0011, 1'b1);
    expect_word("ill.jump", 2, 0, 1);
    check("ill.cnt", int'(err_cnt8), 1);
    drive(1'b0, 1'b1, 4'b0010, 1'b1);
    expect_word("ill.recover", 3, 1, 0);

    // Backpressure
    do_reset();
    drive(1'b0, 1'b1, 4'b0111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 4'b0101, 1'b0);
      check("bp.valid", int'(out_valid8), 1);
      check("bp.bin", int'(bin_out8), 5);
      check("bp.ready", int'(in_ready8), 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", int'(in_ready8), 1);
    @(posedge clk); #1;
    expect_word("bp.pass", 6, 1, 0);

    // Saturation and repeat
    do_reset();
    drive(1'b0, 1'b1, 4'b0001, 1'b1);
    drive(1'b0, 1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, (i % 2 == 0) ? 4'b0011 : 4'b0000, 1'b1);
      check("sat.err", int'(step_err2), 1);
      check("sat.cnt2", int'(err_cnt2), (i < 3) ? i + 1 : 3);
      check("sat.cnt8", int'(err_cnt8), i + 1);
    end
    drive(1'b0, 1'b1, 4'b0011, 1'b1);
    expect_word("sat.repeat", 2, 0, 0);
    check("sat.repeat_cnt", int'(err_cnt2), 3);

    // Reset while a word is held under backpressure
    drive(1'b0, 1'b1, 4'b0000, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 1'b0);
    check("mid.held", int'(out_valid8), 1);
    drive(1'b1, 1'b0, 4'b0000, 1'b0);
    check("mid.valid", int'(out_valid8), 0);
    check("mid.cnt", int'(err_cnt8), 0);
    check("mid.dir", int'(dir_up8), 1);
    drive(1'b0, 1'b1, 4'b0111, 1'b1);
    expect_word("mid.first", 5, 1, 0);

    // Randomized traffic
    cur = 4'd0;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      cur = cur ^ (4'b0001 << $urandom_range(0, 3));
      else if (r < 75) cur = cur;
      else             cur = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), cur,
            ($urandom_range(0, 9) < 7));
    end
    drive(1'b0, 1'b0, cur, 1'b1);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
